pipe_maindec: RTL and testbench

//  Registered, handshaked main decoder for the ID stage of the pipeline.

---
 rtl/pipe_maindec_if.sv | 25 ++
 rtl/pipe_maindec.sv | 140 ++++++++++++++
 tb/tb_pipe_maindec.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_maindec_if.sv
// Bundle between IF/ID, the main decoder and EX.
// valid/ready: a beat transfers on a rising edge where valid && ready; the sender holds its payload stable while valid && !ready.
interface pipe_maindec_if;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] op;
  logic [4:0] rt;
  logic [5:0] funct;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] control;
  logic       illegal;
  logic       hilo_busy;
  logic       dbg_state;

  modport master (
    output in_valid, op, rt, funct, out_ready,
    input  in_ready, out_valid, control, illegal, hilo_busy, dbg_state
  );

  modport slave (
    input  in_valid, op, rt, funct, out_ready,
    output in_ready, out_valid, control, illegal, hilo_busy, dbg_state
  );
endinterface

// File: rtl/pipe_maindec.sv
// Registered ID-stage main decoder: op/funct -> 9-bit control bundle to EX,
// with issue blocked while a multi-cycle MULT/DIV occupies the HI/LO unit.
module pipe_maindec #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter bit EN_DIV     = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  pipe_maindec_if.slave   bus
);
  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          out_valid_q, out_valid_d;
  logic [8:0]    control_q, control_d;
  logic          illegal_q, illegal_d;

  logic [8:0]    ctrl_dec;
  logic          ill_dec;
  logic          is_mul;
  logic          is_div;
  logic          in_ready;
  logic          accept;

  // Control bits: HiLoWr Link RegWr RegDst AluSrc Branch MemWr MemtoReg Jump
  always_comb begin
    ctrl_dec = '0;
    ill_dec  = 1'b0;
    is_mul   = 1'b0;
    is_div   = 1'b0;
    case (bus.op)
      6'b000000: begin
        case (bus.funct)
          6'h18, 6'h19: begin
            ctrl_dec = 9'b1_0_0100000;
            is_mul   = 1'b1;
          end
          6'h1A, 6'h1B: begin
            if (EN_DIV) begin
              ctrl_dec = 9'b1_0_0100000;
              is_div   = 1'b1;
            end else begin
              ill_dec = 1'b1;
            end
          end
          default: ctrl_dec = 9'b0_0_1100000;
        endcase
      end
      6'b000001: begin
        if (bus.rt == 5'd0 || bus.rt == 5'd1) ctrl_dec = 9'b0_0_0001000;
        else                                   ill_dec  = 1'b1;
      end
      6'b000010:                                  ctrl_dec = 9'b0_0_0000001;
      6'b000011:                                  ctrl_dec = 9'b0_1_1000001;
      6'b000100, 6'b000101, 6'b000110, 6'b000111: ctrl_dec = 9'b0_0_0001000;
      6'b001000, 6'b001010, 6'b001100,
      6'b001101, 6'b001110, 6'b001111:            ctrl_dec = 9'b0_0_1010000;
      6'b100011:                                  ctrl_dec = 9'b0_0_1010010;
      6'b101011:                                  ctrl_dec = 9'b0_0_0010100;
      default:                                    ill_dec  = 1'b1;
    endcase
  end

  assign in_ready = !flush && (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  // Output register: load on accept, drain on handshake, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    control_d   = control_q;
    illegal_d   = illegal_q;
    if (accept) begin
      out_valid_d = 1'b1;
      control_d   = ctrl_dec;
      illegal_d   = ill_dec;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (flush) out_valid_d = 1'b0;
  end

  // HI/LO occupancy: count holds remaining busy cycles minus one.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && is_mul) begin
          state_d = ST_BUSY;
          count_d = CW'(MUL_CYCLES - 1);
        end else if (accept && is_div) begin
          state_d = ST_BUSY;
          count_d = CW'(DIV_CYCLES - 1);
        end
      end
      ST_BUSY: begin
        if (count_q == '0) state_d = ST_IDLE;
        else               count_d = count_q - 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
    if (flush) begin
      state_d = ST_IDLE;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      control_q   <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      control_q   <= control_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.control   = control_q;
  assign bus.illegal   = illegal_q && out_valid_q;
  assign bus.hilo_busy = (state_q == ST_BUSY);
  assign bus.dbg_state = state_q[0];
endmodule

// File: tb/tb_pipe_maindec.sv
// Bench for pipe_maindec: decode table, multi-cycle corner sequences and
// randomized traffic against a behavioural model.
module tb_pipe_maindec;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_maindec_if bus ();
  pipe_maindec_if bus_nd ();

  pipe_maindec u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
  );

  pipe_maindec #(.EN_DIV(1'b0)) u_nodiv (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus_nd.slave)
  );

  typedef struct {
    logic [5:0] op;
    logic [4:0] rt;
    logic [5:0] fn;
    logic [8:0] ctrl;
    logic       ill;
    logic       busy;
  } vec_t;

  vec_t vecs[23];
  logic [9:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rt,
                       input logic [5:0] fn, input logic ordy, input logic fl);
    bus.in_valid     = v;
    bus.op           = op;
    bus.rt           = rt;
    bus.funct        = fn;
    bus.out_ready    = ordy;
    bus_nd.in_valid  = v;
    bus_nd.op        = op;
    bus_nd.rt        = rt;
    bus_nd.funct     = fn;
    bus_nd.out_ready = ordy;
    flush            = fl;
  endtask

  task automatic wait_ready(input string name, input int budget);
    int n;
    n = 0;
    drive(1'b0, 6'h00, 5'd0, 6'h00, 1'b1, 1'b0);
    while (bus.in_ready !== 1'b1) begin
      if (n >= budget) begin
        checks++;
        errors++;
        $display("FAIL %s timeout waiting for in_ready after %0d cycles", name, n);
        return;
      end
      @(negedge clk);
      #1;
      n++;
    end
  endtask

  // Reference decode, built field by field from the instruction class.
  function automatic void ref_decode(input logic [5:0] op, input logic [4:0] rt,
                                     input logic [5:0] fn, input bit en_div,
                                     output logic [9:0] b, output int busy);
    bit hilowr, link, regwr, regdst, alusrc, branch, memwr, memtoreg, jump, ill;
    {hilowr, link, regwr, regdst, alusrc, branch, memwr, memtoreg, jump, ill} = '0;
    busy = 0;
    if (op == 6'h00) begin
      if (fn inside {[6'h18:6'h1B]}) begin
        if (fn >= 6'h1A && !en_div) ill = 1'b1;
        else begin
          hilowr = 1'b1;
          regdst = 1'b1;
          busy   = (fn >= 6'h1A) ? 32 : 4;
        end
      end else begin
        regwr  = 1'b1;
        regdst = 1'b1;
      end
    end else if (op inside {[6'h04:6'h07]} || (op == 6'h01 && rt <= 5'd1)) begin
      branch = 1'b1;
    end else if (op inside {6'h08, 6'h0A, [6'h0C:6'h0F]}) begin
      regwr  = 1'b1;
      alusrc = 1'b1;
    end else if (op == 6'h23) begin
      regwr    = 1'b1;
      alusrc   = 1'b1;
      memtoreg = 1'b1;
    end else if (op == 6'h2B) begin
      alusrc = 1'b1;
      memwr  = 1'b1;
    end else if (op == 6'h02) begin
      jump = 1'b1;
    end else if (op == 6'h03) begin
      link  = 1'b1;
      regwr = 1'b1;
      jump  = 1'b1;
    end else begin
      ill = 1'b1;
    end
    b = {ill, hilowr, link, regwr, regdst, alusrc, branch, memwr, memtoreg, jump};
  endfunction

  function automatic vec_t mk(input logic [5:0] op, input logic [4:0] rt, input logic [5:0] fn,
                              input logic [8:0] ctrl, input logic ill, input logic busy);
    vec_t v;
    v.op = op; v.rt = rt; v.fn = fn; v.ctrl = ctrl; v.ill = ill; v.busy = busy;
    return v;
  endfunction

  initial begin
    logic [5:0] ops_pool[16];
    ops_pool = '{6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06,
                 6'h07, 6'h08, 6'h0A, 6'h0C, 6'h0F, 6'h23, 6'h2B, 6'h3F};

    vecs[0]  = mk(6'h23, 5'd0, 6'h00, 9'h052, 1'b0, 1'b0);
    vecs[1]  = mk(6'h2B, 5'd0, 6'h00, 9'h014, 1'b0, 1'b0);
    vecs[2]  = mk(6'h00, 5'd0, 6'h20, 9'h060, 1'b0, 1'b0);
    vecs[3]  = mk(6'h00, 5'd0, 6'h18, 9'h120, 1'b0, 1'b1);
    vecs[4]  = mk(6'h00, 5'd0, 6'h19, 9'h120, 1'b0, 1'b1);
    vecs[5]  = mk(6'h00, 5'd0, 6'h1A, 9'h120, 1'b0, 1'b1);
    vecs[6]  = mk(6'h00, 5'd0, 6'h1B, 9'h120, 1'b0, 1'b1);
    vecs[7]  = mk(6'h04, 5'd0, 6'h00, 9'h008, 1'b0, 1'b0);
    vecs[8]  = mk(6'h05, 5'd3, 6'h00, 9'h008, 1'b0, 1'b0);
    vecs[9]  = mk(6'h06, 5'd0, 6'h00, 9'h008, 1'b0, 1'b0);
    vecs[10] = mk(6'h07, 5'd0, 6'h00, 9'h008, 1'b0, 1'b0);
    vecs[11] = mk(6'h01, 5'd0, 6'h00, 9'h008, 1'b0, 1'b0);
    vecs[12] = mk(6'h01, 5'd1, 6'h00, 9'h008, 1'b0, 1'b0);
    vecs[13] = mk(6'h01, 5'd2, 6'h00, 9'h000, 1'b1, 1'b0);
    vecs[14] = mk(6'h08, 5'd0, 6'h00, 9'h050, 1'b0, 1'b0);
    vecs[15] = mk(6'h0A, 5'd0, 6'h00, 9'h050, 1'b0, 1'b0);
    vecs[16] = mk(6'h0C, 5'd0, 6'h00, 9'h050, 1'b0, 1'b0);
    vecs[17] = mk(6'h0E, 5'd0, 6'h00, 9'h050, 1'b0, 1'b0);
    vecs[18] = mk(6'h0F, 5'd0, 6'h00, 9'h050, 1'b0, 1'b0);
    vecs[19] = mk(6'h02, 5'd0, 6'h00, 9'h001, 1'b0, 1'b0);
    vecs[20] = mk(6'h03, 5'd0, 6'h00, 9'h0C1, 1'b0, 1'b0);
    vecs[21] = mk(6'h3F, 5'd0, 6'h00, 9'h000, 1'b1, 1'b0);
    vecs[22] = mk(6'h09, 5'd0, 6'h00, 9'h000, 1'b1, 1'b0);

    // Clock/reset
    drive(1'b0, 6'h00, 5'd0, 6'h00, 1'b1, 1'b0);
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_control", bus.control, 9'h000);
    check("rst_illegal", bus.illegal, 1'b0);
    check("rst_hilo_busy", bus.hilo_busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", bus.in_ready, 1'b1);

    // Decode table
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      drive(1'b1, vecs[i].op, vecs[i].rt, vecs[i].fn, 1'b1, 1'b0);
      #1;
      check($sformatf("tbl%0d_in_ready", i), bus.in_ready, 1'b1);
      @(negedge clk);
      drive(1'b0, 6'h00, 5'd0, 6'h00, 1'b1, 1'b0);
      #1;
      check($sformatf("tbl%0d_out_valid", i), bus.out_valid, 1'b1);
      check($sformatf("tbl%0d_control", i), bus.control, vecs[i].ctrl);
      check($sformatf("tbl%0d_illegal", i), bus.illegal, vecs[i].ill);
      check($sformatf("tbl%0d_hilo_busy", i), bus.hilo_busy, vecs[i].busy);
      wait_ready($sformatf("tbl%0d_drain", i), 40);
    end

    // Backpressure hold
    @(negedge clk);
    drive(1'b1, 6'h08, 5'd0, 6'h00, 1'b0, 1'b0);
    #1;
    check("bp_accept_ready", bus.in_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b0, 6'h00, 5'd0, 6'h00, 1'b0, 1'b0);
      #1;
      check("bp_out_valid", bus.out_valid, 1'b1);
      check("bp_control_held", bus.control, 9'h050);
      check("bp_in_ready_low", bus.in_ready, 1'b0);
    end
    @(negedge clk);
    drive(1'b0, 6'h00, 5'd0, 6'h00, 1'b1, 1'b0);
    #1;
    check("bp_release_ready", bus.in_ready, 1'b1);
    check("bp_release_control", bus.control, 9'h050);
    @(negedge clk);
    #1;
    check("bp_drained", bus.out_valid, 1'b0);

    // MULT busy window of exactly 4 cycles
    @(negedge clk);
    drive(1'b1, 6'h00, 5'd0, 6'h18, 1'b1, 1'b0);
    #1;
    check("mul_accept_ready", bus.in_ready, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1'b0, 6'h00, 5'd0, 6'h00, 1'b1, 1'b0);
      #1;
      check($sformatf("mul_busy%0d", k), bus.hilo_busy, 1'b1);
      check($sformatf("mul_ready_low%0d", k), bus.in_ready, 1'b0);
      if (k == 0) begin
        check("mul_out_valid", bus.out_valid, 1'b1);
        check("mul_control", bus.control, 9'h120);
      end
    end
    @(negedge clk);
    #1;
    check("mul_busy_end", bus.hilo_busy, 1'b0);
    check("mul_ready_end", bus.in_ready, 1'b1);

    // Flush in DIV busy cycle 5 with a competing in_valid
    @(negedge clk);
    drive(1'b1, 6'h00, 5'd0, 6'h1A, 1'b0, 1'b0);
    #1;
    check("div_accept_ready", bus.in_ready, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      drive(1'b0, 6'h00, 5'd0, 6'h00, 1'b0, 1'b0);
      #1;
      check($sformatf("div_busy%0d", k), bus.hilo_busy, 1'b1);
    end
    @(negedge clk);
    drive(1'b1, 6'h08, 5'd0, 6'h00, 1'b0, 1'b1);
    #1;
    check("flush_blocks_ready", bus.in_ready, 1'b0);
    check("flush_pre_valid", bus.out_valid, 1'b1);
    @(negedge clk);
    drive(1'b0, 6'h00, 5'd0, 6'h00, 1'b0, 1'b0);
    #1;
    check("flush_out_valid", bus.out_valid, 1'b0);
    check("flush_hilo_busy", bus.hilo_busy, 1'b0);
    check("flush_ready", bus.in_ready, 1'b1);

    // DIV on the EN_DIV=0 instance is illegal and never busy
    @(negedge clk);
    drive(1'b1, 6'h00, 5'd0, 6'h1B, 1'b1, 1'b0);
    #1;
    check("nodiv_ready", bus_nd.in_ready, 1'b1);
    @(negedge clk);
    drive(1'b0, 6'h00, 5'd0, 6'h00, 1'b1, 1'b0);
    #1;
    check("nodiv_out_valid", bus_nd.out_valid, 1'b1);
    check("nodiv_illegal", bus_nd.illegal, 1'b1);
    check("nodiv_control", bus_nd.control, 9'h000);
    check("nodiv_hilo_busy", bus_nd.hilo_busy, 1'b0);
    wait_ready("nodiv_drain", 40);

    // Asynchronous reset in the middle of a MULT busy window
    @(negedge clk);
    drive(1'b1, 6'h00, 5'd0, 6'h19, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 6'h00, 5'd0, 6'h00, 1'b0, 1'b0);
    #1;
    check("arst_pre_busy", bus.hilo_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", bus.out_valid, 1'b0);
    check("arst_hilo_busy", bus.hilo_busy, 1'b0);
    check("arst_control", bus.control, 9'h000);
    check("arst_illegal", bus.illegal, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 6'h00, 5'd0, 6'h00, 1'b1, 1'b0);
    #1;
    check("arst_ready", bus.in_ready, 1'b1);

    // Randomized traffic against the behavioural model
    begin
      int         busy_left;
      logic       v, ordy, fl, exp_ready;
      logic [5:0] op, fn;
      logic [4:0] rt;
      logic [9:0] b;
      int         bc;
      busy_left = 0;
      exp_q.delete();
      for (int cyc = 0; cyc < 3000; cyc++) begin
        @(negedge clk);
        v    = ($urandom_range(0, 9) < 6);
        op   = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63))
                                            : ops_pool[$urandom_range(0, 15)];
        rt   = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
        fn   = ($urandom_range(0, 1) == 1) ? 6'(6'h18 + $urandom_range(0, 3))
                                            : 6'($urandom_range(0, 63));
        ordy = ($urandom_range(0, 9) < 7);
        fl   = ($urandom_range(0, 39) == 0);
        drive(v, op, rt, fn, ordy, fl);
        #1;
        exp_ready = !fl && (busy_left == 0) && (exp_q.size() == 0 || ordy);
        check("rnd_in_ready", bus.in_ready, exp_ready);
        check("rnd_out_valid", bus.out_valid, exp_q.size() != 0);
        check("rnd_hilo_busy", bus.hilo_busy, busy_left > 0);
        if (exp_q.size() != 0) begin
          check("rnd_control", bus.control, exp_q[0][8:0]);
          check("rnd_illegal", bus.illegal, exp_q[0][9]);
        end else begin
          check("rnd_illegal_idle", bus.illegal, 1'b0);
        end
        @(posedge clk);
        if (fl) begin
          exp_q.delete();
          busy_left = 0;
        end else if (v && exp_ready) begin
          ref_decode(op, rt, fn, 1'b1, b, bc);
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          exp_q.push_back(b);
          busy_left = bc;
        end else begin
          if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
          if (busy_left > 0) busy_left--;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
